scan_display_ctrl: RTL

Sequencing controller for the 8-digit multiplexed 7-segment display. Holds a double-buffered 32-bit hex value plus per-digit decimal-point and enable masks, and steps through the digits at a parameterised slot rate, with a dead-time blank at the start of each slot to suppress ghosting. It drives active-low digit enables and segment lines. Producers (CPU debug port, register/PC monitor) update the buffer through a load/ack handshake. Updates commit only on frame boundaries, so a frame never mixes old and new data.

---
 rtl/scan_display_ctrl_if.sv | 25 ++
 rtl/scan_display_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/scan_display_ctrl_if.sv
// Bundle between a display producer and the 7-segment scan controller.
// master: producer side (drives en, data_in, dp_in, mask_in, load; sees load_ack and the display lines).
// slave : controller side (inverse directions).
interface scan_display_ctrl_if;
  logic        en;           // scan enable; 0 blanks the display and restarts the frame
  logic [31:0] data_in;      // digit k shows data_in[4k+3:4k]
  logic [7:0]  dp_in;        // per-digit decimal point, 1 = lit
  logic [7:0]  mask_in;      // per-digit enable, 1 = shown
  logic        load;         // capture request for data_in/dp_in/mask_in
  logic        load_ack;     // one-cycle pulse when captured data becomes active
  logic [7:0]  an;           // active-low digit enables
  logic [7:0]  seg;          // active-low segments {dp,g,f,e,d,c,b,a}
  logic [2:0]  sel;          // current digit slot
  logic        frame_start;  // one-cycle pulse on the first cycle of slot 0

  modport master (
    output en, data_in, dp_in, mask_in, load,
    input  load_ack, an, seg, sel, frame_start
  );

  modport slave (
    input  en, data_in, dp_in, mask_in, load,
    output load_ack, an, seg, sel, frame_start
  );
endinterface

// File: rtl/scan_display_ctrl.sv
// Scan controller for an 8-digit multiplexed 7-segment display with double-buffered data.
// Ports: clk, reset (async active-low), bus (slave modport): en/data_in/dp_in/mask_in/load in;
//        load_ack/an/seg/sel/frame_start out, all registered.
module scan_display_ctrl #(
  parameter int unsigned DIV       = 50000,  // cycles per digit slot
  parameter int unsigned BLANK_CYC = 4       // dead-time cycles at the start of each slot
) (
  input  logic               clk,
  input  logic               reset,
  scan_display_ctrl_if.slave bus
);

  localparam int unsigned      CNT_W      = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       sel, sel_d;

  // Shadow buffer written by producers, active buffer read by the scanner.
  logic [31:0] shadow_data, act_data;
  logic [7:0]  shadow_dp, act_dp;
  logic [7:0]  shadow_mask, act_mask;
  logic        pending;

  logic [7:0]  an_q, an_d;
  logic [7:0]  seg_q, seg_d;
  logic        ack_q;
  logic        fs_q, fs_d;

  logic        wrap;     // last cycle of slot 7 with scanning continuing
  logic        commit;   // shadow -> active this cycle
  logic [3:0]  nib;
  logic [7:0]  dec;

  // Active-low hex decode; bit 7 (dp) is replaced by the caller.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // Next-state logic. Dropping en lands in IDLE, which always re-enters at slot 0,
  // so even a single low cycle restarts the frame.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sel_d   = sel;
    wrap    = 1'b0;
    if (!bus.en) begin
      state_d = IDLE;
      cnt_d   = '0;
      sel_d   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = '0;
          sel_d   = '0;
        end
        BLANK: begin
          cnt_d = cnt + 1'b1;
          if (cnt == BLANK_LAST) begin
            state_d = SHOW;
          end
        end
        SHOW: begin
          if (cnt == CNT_LAST) begin
            cnt_d   = '0;
            sel_d   = sel + 1'b1;
            state_d = BLANK;
            wrap    = (sel == 3'd7);
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          sel_d   = '0;
        end
      endcase
    end
  end

  // Commits only at frame boundaries so a frame never mixes buffers; in IDLE there
  // is no frame in flight, so pending data is taken immediately.
  assign commit = pending && ((state == IDLE) || wrap);

  // frame_start marks entry into BLANK of slot 0, from IDLE or from the 7->0 wrap.
  assign fs_d = ((state == IDLE) && bus.en) || wrap;

  // Output values are computed for the state being entered so that an/seg are
  // registered yet line up cycle-for-cycle with state. The active buffer only
  // changes on edges entering BLANK/IDLE, so reading it here is never stale in SHOW.
  always_comb begin
    nib   = act_data[{sel_d, 2'b00} +: 4];
    dec   = hex_to_seg(nib);
    an_d  = 8'hFF;
    seg_d = 8'hFF;
    if (state_d == SHOW) begin
      an_d  = act_mask[sel_d] ? ~(8'b1 << sel_d) : 8'hFF;
      seg_d = {~act_dp[sel_d], dec[6:0]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      sel   <= '0;
      an_q  <= 8'hFF;
      seg_q <= 8'hFF;
      ack_q <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      sel   <= sel_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      ack_q <= commit;
      fs_q  <= fs_d;
    end
  end

  // Last write wins in the shadow; a load coinciding with a commit keeps pending
  // set so the newer data gets its own commit at the next boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_data <= '0;
      shadow_dp   <= '0;
      shadow_mask <= '0;
      pending     <= 1'b0;
    end else if (bus.load) begin
      shadow_data <= bus.data_in;
      shadow_dp   <= bus.dp_in;
      shadow_mask <= bus.mask_in;
      pending     <= 1'b1;
    end else if (commit) begin
      pending     <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_data <= '0;
      act_dp   <= '0;
      act_mask <= '0;
    end else if (commit) begin
      act_data <= shadow_data;
      act_dp   <= shadow_dp;
      act_mask <= shadow_mask;
    end
  end

  assign bus.an          = an_q;
  assign bus.seg         = seg_q;
  assign bus.sel         = sel;
  assign bus.load_ack    = ack_q;
  assign bus.frame_start = fs_q;

endmodule
